// File: rtl/hamming_secded_encoder.sv
// Pipelined Hamming / SEC-DED encoder with valid/ready handshakes on both sides.
// Two-stage pipeline (s1 = data, s2 = codeword), single-bit injection and a transfer counter.
module hamming_secded_encoder #(
    parameter int DATA_W = 16,
    parameter int SECDED = 1,
    // Smallest p with 2^p >= DATA_W + p + 1, expressed as DATA_W thresholds.
    localparam int P = (DATA_W <= 1)    ? 2  :
                       (DATA_W <= 4)    ? 3  :
                       (DATA_W <= 11)   ? 4  :
                       (DATA_W <= 26)   ? 5  :
                       (DATA_W <= 57)   ? 6  :
                       (DATA_W <= 120)  ? 7  :
                       (DATA_W <= 247)  ? 8  :
                       (DATA_W <= 502)  ? 9  :
                       (DATA_W <= 1013) ? 10 : 11,
    localparam int CODE_W = DATA_W + P + SECDED,
    localparam int IDX_W  = $clog2(CODE_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    input  logic              inj_en,
    input  logic [IDX_W-1:0]  inj_pos,
    output logic [31:0]       word_cnt
);

    localparam int HAM_W = DATA_W + P;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s2_valid;
    logic [CODE_W-1:0] s2_code;

    logic              s1_load;
    logic              s2_load;
    logic [HAM_W-1:0]  placed;
    logic [HAM_W-1:0]  ham_code;
    logic [CODE_W-1:0] enc_code;
    logic              inj_hit;
    logic [CODE_W-1:0] inj_mask;

    // Data bit i sits at the (i+1)-th non-power-of-two position j; i = j - 1 - clog2(j+1).
    for (genvar j = 1; j <= HAM_W; j++) begin : g_place
        if ((j & (j - 1)) != 0) begin : g_data
            assign placed[j-1] = s1_data[j-1-$clog2(j+1)];
        end else begin : g_par
            assign placed[j-1] = 1'b0;
        end
    end

    // NOTE: every variable written here gets a value before any conditional use,
    // so no latch is inferred for ham_code or par.
    always_comb begin
        logic par;
        ham_code = placed;
        par      = 1'b0;
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int j = 1; j <= HAM_W; j++) begin
                if ((((j >> k) & 1) == 1) && ((j & (j - 1)) != 0)) begin
                    par = par ^ placed[j-1];
                end
            end
            ham_code[(1 << k) - 1] = par;
        end
    end

    if (SECDED != 0) begin : g_secded
        assign enc_code = {^ham_code, ham_code};
    end else begin : g_sec
        assign enc_code = ham_code;
    end

    // Out-of-range positions leave the word untouched rather than aliasing.
    assign inj_hit  = inj_en && (32'(inj_pos) < CODE_W);
    assign inj_mask = inj_hit ? (CODE_W'(1) << inj_pos) : '0;

    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_code  <= '0;
            word_cnt <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_code  <= enc_code ^ inj_mask;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end

            if (s2_valid && out_ready) begin
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_code  = s2_code;

endmodule
